// File: rtl/chronos_mem_harness.sv
// Shared single-ported word RAM for the Chronos RV32I harness: round-robin imem/dmem
// arbitration, configurable response latency, byte-strobed stores and tohost/fromhost MMIO.
module chronos_mem_harness #(
    parameter int               XLEN          = 32,
    parameter int               DEPTH_WORDS   = 4096,
    parameter int               LATENCY       = 1,
    parameter logic [XLEN-1:0]  BASE_ADDR     = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TOHOST_ADDR   = 32'h8000_1000,
    parameter logic [XLEN-1:0]  FROMHOST_ADDR = 32'h8000_1040
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req_val,
    output logic                imem_req_rdy,
    input  logic [XLEN-1:0]     imem_req_addr,
    output logic                imem_resp_val,
    output logic [XLEN-1:0]     imem_resp_data,
    output logic                imem_resp_err,
    input  logic                dmem_req_val,
    output logic                dmem_req_rdy,
    input  logic                dmem_req_rw,
    input  logic [XLEN-1:0]     dmem_req_addr,
    input  logic [XLEN-1:0]     dmem_req_wdata,
    input  logic [XLEN/8-1:0]   dmem_req_wstrb,
    output logic                dmem_resp_val,
    output logic [XLEN-1:0]     dmem_resp_data,
    output logic                dmem_resp_err,
    output logic [XLEN-1:0]     testrig_tohost,
    output logic                testrig_tohost_val,
    input  logic [XLEN-1:0]     testrig_fromhost
);
    localparam int              AW        = $clog2(DEPTH_WORDS);
    localparam int              SW        = XLEN / 8;
    localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH_WORDS * 4);
    localparam logic [3:0]      CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic             last_grant_q;   // 1 = dmem was granted last
    logic             owner_q;        // port owning the in-flight transaction, 1 = dmem
    logic             tohost_pend_q;
    logic [XLEN-1:0]  tohost_q;
    logic [XLEN-1:0]  mem [DEPTH_WORDS];

    logic             gnt_i, gnt_d, accept, resp_fire;
    logic [XLEN-1:0]  i_off, d_off, d_load_data;
    logic [AW-1:0]    i_idx, d_idx;
    logic             i_ok, d_tohost, d_fromhost, d_ram, d_err;

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                    input logic [XLEN-1:0] new_w,
                                                    input logic [SW-1:0]   strb);
        logic [XLEN-1:0] r;
        r = old_w;
        for (int i = 0; i < SW; i++)
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Address decode; MMIO is invisible to the fetch port
    assign i_off      = imem_req_addr - BASE_ADDR;
    assign d_off      = dmem_req_addr - BASE_ADDR;
    assign i_idx      = i_off[AW+1:2];
    assign d_idx      = d_off[AW+1:2];
    assign i_ok       = (imem_req_addr[1:0] == 2'b00) && (i_off < RAM_BYTES) &&
                        (imem_req_addr != TOHOST_ADDR) && (imem_req_addr != FROMHOST_ADDR);
    assign d_tohost   = (dmem_req_addr == TOHOST_ADDR);
    assign d_fromhost = !d_tohost && (dmem_req_addr == FROMHOST_ADDR);
    assign d_ram      = !d_tohost && !d_fromhost && (dmem_req_addr[1:0] == 2'b00) &&
                        (d_off < RAM_BYTES);
    assign d_err      = !(d_tohost || d_fromhost || d_ram);

    always_comb begin
        d_load_data = '0;
        if (!dmem_req_rw && !d_err) begin
            if (d_tohost)        d_load_data = tohost_q;
            else if (d_fromhost) d_load_data = testrig_fromhost;
            else                 d_load_data = mem[d_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (cnt_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants are gated by reset so nothing is committed while rst is held low
    always_comb begin
        gnt_i         = 1'b0;
        gnt_d         = 1'b0;
        if (rst && state_q == IDLE) begin
            gnt_i = imem_req_val && (!dmem_req_val || last_grant_q);
            gnt_d = dmem_req_val && (!imem_req_val || !last_grant_q);
        end
        accept             = gnt_i || gnt_d;
        imem_req_rdy       = gnt_i;
        dmem_req_rdy       = gnt_d;
        resp_fire          = (state_q == BUSY) && (cnt_q == 4'd0);
        imem_resp_val      = resp_fire && !owner_q;
        dmem_resp_val      = resp_fire && owner_q;
        testrig_tohost_val = resp_fire && owner_q && tohost_pend_q;
    end

    assign testrig_tohost = tohost_q;

    // Accept edge: capture response, commit MMIO write, load latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            tohost_pend_q  <= 1'b0;
            tohost_q       <= '0;
            imem_resp_data <= '0;
            imem_resp_err  <= 1'b0;
            dmem_resp_data <= '0;
            dmem_resp_err  <= 1'b0;
        end else if (accept) begin
            cnt_q         <= CNT_LOAD;
            last_grant_q  <= gnt_d;
            owner_q       <= gnt_d;
            tohost_pend_q <= gnt_d && dmem_req_rw && d_tohost;
            if (gnt_i) begin
                imem_resp_data <= i_ok ? mem[i_idx] : '0;
                imem_resp_err  <= !i_ok;
            end else begin
                dmem_resp_data <= d_load_data;
                dmem_resp_err  <= d_err;
                if (dmem_req_rw && d_tohost)
                    tohost_q <= merge_bytes(tohost_q, dmem_req_wdata, dmem_req_wstrb);
            end
        end else if (state_q == BUSY && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_d && dmem_req_rw && d_ram)
            mem[d_idx] <= merge_bytes(mem[d_idx], dmem_req_wdata, dmem_req_wstrb);
    end

endmodule

// File: tb/tb_chronos_mem_harness.sv
// Directed scoreboard bench: a LATENCY=1 instance for the main function and a LATENCY=3
// instance for latency and mid-transaction reset behaviour.
module tb_chronos_mem_harness;
    localparam logic [31:0] TOHOST   = 32'h8000_1000;
    localparam logic [31:0] FROMHOST = 32'h8000_1040;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        i_val, i_rdy, i_rval, i_rerr;
    logic [31:0] i_addr, i_rdata;
    logic        d_val, d_rdy, d_rw, d_rval, d_rerr;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] tohost, fromhost;
    logic        tohost_val;

    logic        l3_i_val, l3_i_rdy, l3_i_rval, l3_i_rerr;
    logic [31:0] l3_i_addr, l3_i_rdata;
    logic        l3_d_val, l3_d_rdy, l3_d_rw, l3_d_rval, l3_d_rerr;
    logic [31:0] l3_d_addr, l3_d_wdata, l3_d_rdata;
    logic [3:0]  l3_d_wstrb;
    logic [31:0] l3_tohost, l3_fromhost;
    logic        l3_tohost_val;

    chronos_mem_harness #(.LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_val(i_val), .imem_req_rdy(i_rdy), .imem_req_addr(i_addr),
        .imem_resp_val(i_rval), .imem_resp_data(i_rdata), .imem_resp_err(i_rerr),
        .dmem_req_val(d_val), .dmem_req_rdy(d_rdy), .dmem_req_rw(d_rw),
        .dmem_req_addr(d_addr), .dmem_req_wdata(d_wdata), .dmem_req_wstrb(d_wstrb),
        .dmem_resp_val(d_rval), .dmem_resp_data(d_rdata), .dmem_resp_err(d_rerr),
        .testrig_tohost(tohost), .testrig_tohost_val(tohost_val), .testrig_fromhost(fromhost)
    );

    chronos_mem_harness #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .imem_req_val(l3_i_val), .imem_req_rdy(l3_i_rdy), .imem_req_addr(l3_i_addr),
        .imem_resp_val(l3_i_rval), .imem_resp_data(l3_i_rdata), .imem_resp_err(l3_i_rerr),
        .dmem_req_val(l3_d_val), .dmem_req_rdy(l3_d_rdy), .dmem_req_rw(l3_d_rw),
        .dmem_req_addr(l3_d_addr), .dmem_req_wdata(l3_d_wdata), .dmem_req_wstrb(l3_d_wstrb),
        .dmem_resp_val(l3_d_rval), .dmem_resp_data(l3_d_rdata), .dmem_resp_err(l3_d_rerr),
        .testrig_tohost(l3_tohost), .testrig_tohost_val(l3_tohost_val),
        .testrig_fromhost(l3_fromhost)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   tv_cnt = 0;
    exp_t iq[$];
    exp_t dq[$];
    exp_t d3q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitors: pop the scoreboard and compare data, err and latency
    always @(negedge clk) begin
        exp_t e;
        if (i_rval || d_rval) check("resp_overlap", {31'b0, i_rval & d_rval}, 32'd0);
        if (i_rval) begin
            if (iq.size() == 0) check("imem_unexpected_resp", {31'b0, i_rval}, 32'd0);
            else begin
                e = iq.pop_front();
                check("imem_data", i_rdata, e.data);
                check("imem_err", {31'b0, i_rerr}, {31'b0, e.err});
                check("imem_latency", cyc - e.cyc, 32'd1);
            end
        end
        if (d_rval) begin
            if (dq.size() == 0) check("dmem_unexpected_resp", {31'b0, d_rval}, 32'd0);
            else begin
                e = dq.pop_front();
                check("dmem_data", d_rdata, e.data);
                check("dmem_err", {31'b0, d_rerr}, {31'b0, e.err});
                check("dmem_latency", cyc - e.cyc, 32'd1);
            end
        end
        if (tohost_val) begin
            tv_cnt++;
            check("tohost_val_in_resp_cycle", {31'b0, d_rval}, 32'd1);
        end
        if (l3_i_rval) check("l3_imem_unexpected_resp", {31'b0, l3_i_rval}, 32'd0);
        if (l3_d_rval) begin
            if (d3q.size() == 0) check("l3_dmem_unexpected_resp", {31'b0, l3_d_rval}, 32'd0);
            else begin
                e = d3q.pop_front();
                check("l3_dmem_data", l3_d_rdata, e.data);
                check("l3_dmem_err", {31'b0, l3_d_rerr}, {31'b0, e.err});
                check("l3_dmem_latency", cyc - e.cyc, 32'd3);
            end
        end
    end

    task automatic dreq(input bit l3, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] edata, input logic eerr);
        int   n;
        exp_t e;
        @(negedge clk);
        if (l3) begin
            l3_d_val = 1'b1; l3_d_rw = rw; l3_d_addr = addr; l3_d_wdata = wdata; l3_d_wstrb = strb;
        end else begin
            d_val = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
        end
        #1;
        n = 0;
        while (!(l3 ? l3_d_rdy : d_rdy) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("dmem_req_accept_timeout", {31'b0, n < 50}, 32'd1);
        e.data = edata; e.err = eerr; e.cyc = cyc;
        if (l3) d3q.push_back(e);
        else    dq.push_back(e);
        @(posedge clk); #1;
        if (l3) l3_d_val = 1'b0;
        else    d_val = 1'b0;
    endtask

    task automatic ireq(input logic [31:0] addr, input logic [31:0] edata, input logic eerr);
        int   n;
        exp_t e;
        @(negedge clk);
        i_val = 1'b1; i_addr = addr;
        #1;
        n = 0;
        while (!i_rdy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("imem_req_accept_timeout", {31'b0, n < 50}, 32'd1);
        e.data = edata; e.err = eerr; e.cyc = cyc;
        iq.push_back(e);
        @(posedge clk); #1;
        i_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || d3q.size() != 0) && n < 50) begin
            @(negedge clk); #2; n++;
        end
        check("drain_timeout", {31'b0, n < 50}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int          tv0, ni, nd, k, n;
        logic        gi, gd;
        logic [3:0]  order;
        exp_t        e;

        rst = 1'b0;
        i_val = 1'b0; i_addr = '0;
        d_val = 1'b1; d_rw = 1'b0; d_addr = 32'h20; d_wdata = '0; d_wstrb = '0;
        fromhost = 32'h0000_CAFE;
        l3_i_val = 1'b0; l3_i_addr = '0;
        l3_d_val = 1'b0; l3_d_rw = 1'b0; l3_d_addr = '0; l3_d_wdata = '0; l3_d_wstrb = '0;
        l3_fromhost = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_dmem_rdy", {31'b0, d_rdy}, 32'd0);
        check("reset_imem_resp_val", {31'b0, i_rval}, 32'd0);
        check("reset_dmem_resp_val", {31'b0, d_rval}, 32'd0);
        check("reset_imem_resp_data", i_rdata, 32'd0);
        check("reset_dmem_resp_data", d_rdata, 32'd0);
        check("reset_errs", {30'b0, i_rerr, d_rerr}, 32'd0);
        check("reset_tohost", tohost, 32'd0);
        check("reset_tohost_val", {31'b0, tohost_val}, 32'd0);
        d_val = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Preload via dmem, then fetch
        dreq(0, 1'b1, 32'h10, 32'h0000_0013, 4'hF, 32'h0, 1'b0);
        ireq(32'h10, 32'h0000_0013, 1'b0);
        drain();

        // Byte strobes, including an all-zero strobe
        dreq(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0);
        dreq(0, 1'b1, 32'h20, 32'h0000_0011, 4'h1, 32'h0, 1'b0);
        dreq(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hAABB_CC11, 1'b0);
        dreq(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        dreq(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hAABB_CC11, 1'b0);
        drain();

        // Tohost / fromhost
        tv0 = tv_cnt;
        dreq(0, 1'b1, TOHOST, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
        drain();
        check("tohost_value", tohost, 32'h0000_0001);
        check("tohost_val_pulses", tv_cnt - tv0, 32'd1);
        dreq(0, 1'b0, TOHOST, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
        dreq(0, 1'b1, TOHOST, 32'hAB00_0000, 4'h8, 32'h0, 1'b0);
        drain();
        check("tohost_strobe_merge", tohost, 32'hAB00_0001);
        dreq(0, 1'b0, FROMHOST, 32'h0, 4'h0, 32'h0000_CAFE, 1'b0);
        dreq(0, 1'b1, FROMHOST, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        drain();
        check("tohost_after_fromhost_store", tohost, 32'hAB00_0001);
        check("tohost_val_total", tv_cnt - tv0, 32'd2);

        // Errors and range boundaries
        dreq(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        dreq(0, 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1);
        dreq(0, 1'b1, 32'h4000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
        dreq(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        dreq(0, 1'b1, 32'h21, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
        dreq(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hAABB_CC11, 1'b0);
        dreq(0, 1'b1, 32'h3FFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
        ireq(32'h3FFC, 32'h0BAD_F00D, 1'b0);
        ireq(32'h4000, 32'h0, 1'b1);
        ireq(32'h12, 32'h0, 1'b1);
        ireq(TOHOST, 32'h0, 1'b1);
        drain();

        // Round-robin from reset: imem wins the first tie
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        i_val = 1'b1; i_addr = 32'h10;
        d_val = 1'b1; d_rw = 1'b0; d_addr = 32'h20; d_wstrb = 4'h0;
        #1;
        ni = 2; nd = 1; k = 0; n = 0; order = '0;
        while ((ni > 0 || nd > 0) && n < 40) begin
            gi = i_rdy; gd = d_rdy;
            if (gi || gd) check("rr_single_grant", {31'b0, gi & gd}, 32'd0);
            if (gi && k < 4) begin
                e.data = 32'h0000_0013; e.err = 1'b0; e.cyc = cyc; iq.push_back(e);
                order[k] = 1'b0; k++;
            end
            if (gd && k < 4) begin
                e.data = 32'hAABB_CC11; e.err = 1'b0; e.cyc = cyc; dq.push_back(e);
                order[k] = 1'b1; k++;
            end
            @(posedge clk); #1;
            if (gi) begin ni--; if (ni == 0) i_val = 1'b0; end
            if (gd) begin nd--; if (nd == 0) d_val = 1'b0; end
            @(negedge clk); #1;
            n++;
        end
        i_val = 1'b0; d_val = 1'b0;
        check("rr_grant_count", k, 32'd3);
        check("rr_grant_order", {29'b0, order[2:0]}, 32'b010);
        drain();

        // LATENCY=3: store, then a load abandoned by reset one cycle after accept
        dreq(1, 1'b1, 32'h8, 32'h0000_0055, 4'hF, 32'h0, 1'b0);
        drain();
        @(negedge clk);
        l3_d_val = 1'b1; l3_d_rw = 1'b0; l3_d_addr = 32'h8; l3_d_wstrb = 4'h0;
        #1;
        n = 0;
        while (!l3_d_rdy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("l3_accept_timeout", {31'b0, n < 50}, 32'd1);
        @(posedge clk); #1;
        l3_d_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("l3_reset_resp_val", {31'b0, l3_d_rval}, 32'd0);
        check("l3_reset_resp_data", l3_d_rdata, 32'd0);
        check("l3_reset_resp_err", {31'b0, l3_d_rerr}, 32'd0);
        check("l3_reset_tohost", l3_tohost, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        dreq(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0000_0055, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
